// File: rtl/aes128_type_pkg.sv
// Shared types and register map for the AES-128 core and its bus controller.
// Imported by the controller, its watchdog and the bench.
package aes128_type_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      RUN
   } ctrl_state_t;

   localparam logic [3:0] AES_KEY0   = 4'h0;
   localparam logic [3:0] AES_KEY1   = 4'h1;
   localparam logic [3:0] AES_KEY2   = 4'h2;
   localparam logic [3:0] AES_KEY3   = 4'h3;
   localparam logic [3:0] AES_DATA0  = 4'h4;
   localparam logic [3:0] AES_DATA1  = 4'h5;
   localparam logic [3:0] AES_DATA2  = 4'h6;
   localparam logic [3:0] AES_DATA3  = 4'h7;
   localparam logic [3:0] AES_RES0   = 4'h8;
   localparam logic [3:0] AES_RES1   = 4'h9;
   localparam logic [3:0] AES_RES2   = 4'hA;
   localparam logic [3:0] AES_RES3   = 4'hB;
   localparam logic [3:0] AES_CTRL   = 4'hC;
   localparam logic [3:0] AES_STATUS = 4'hD;

   localparam int CTRL_START   = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_IRQ_CLR = 2;
   localparam int CTRL_OP_LO   = 4;

   localparam int ST_BUSY        = 0;
   localparam int ST_DONE        = 1;
   localparam int ST_IRQ_PEND    = 2;
   localparam int ST_ERR_BUSY    = 3;
   localparam int ST_ERR_TIMEOUT = 4;

endpackage

// File: rtl/aes128_ctrl_watchdog.sv
// Loadable down-counter bounding how long the controller waits in RUN.
// expired_o flags the enabled decrement that takes the count to zero.
module aes128_ctrl_watchdog
   import aes128_type_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= W'(TIMEOUT_CYCLES);
      end else if (en_i && count_q != '0) begin
         count_q <= count_q - W'(1);
      end
   end

   assign expired_o = en_i && (count_q == W'(1));

endmodule

// File: rtl/aes128_ctrl.sv
// Bus-facing sequencer for the AES-128 core: key/data staging, start,
// watchdog-guarded completion, result capture, status and interrupt.
module aes128_ctrl
   import aes128_type_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [3:0]   addr_i,
   input  logic [31:0]  wdata_i,
   input  logic         wr_i,
   input  logic         rd_i,
   output logic [31:0]  rdata_o,
   output logic         rvalid_o,
   output logic         irq_o,
   output logic         core_start_o,
   output logic [1:0]   core_op_o,
   output logic [127:0] core_key_o,
   output logic [127:0] core_data_o,
   input  logic [127:0] core_result_i,
   input  logic         core_valid_i,
   input  logic         core_ready_i
);

   ctrl_state_t state_q, state_d;

   logic [127:0] key_q, data_q, result_q;
   logic [31:0]  rdata_q, rd_mux;
   logic [1:0]   op_q, core_op_q;
   logic         rvalid_q, run_first_q;
   logic         irq_en_q, irq_pend_q, done_q;
   logic         err_busy_q, err_to_q;
   logic         busy, wr_key, wr_data, wr_ctrl, wr_status;
   logic         start_req, launch_ok, reject;
   logic         done_evt, tout_evt;
   logic         wd_load, wd_en, wd_expired;

   assign busy      = (state_q != IDLE);
   assign wr_key    = wr_i && (addr_i[3:2] == 2'b00);
   assign wr_data   = wr_i && (addr_i[3:2] == 2'b01);
   assign wr_ctrl   = wr_i && (addr_i == AES_CTRL);
   assign wr_status = wr_i && (addr_i == AES_STATUS);
   assign start_req = wr_ctrl && wdata_i[CTRL_START];
   assign launch_ok = start_req && !busy && core_ready_i;
   assign reject    = (busy && (wr_key || wr_data || start_req))
                   || (start_req && !busy && !core_ready_i);

   // The core drops a stale valid on the start edge, so skip RUN's first cycle.
   assign done_evt = (state_q == RUN) && !run_first_q && core_valid_i;
   assign tout_evt = (state_q == RUN) && wd_expired && !done_evt;
   assign wd_load  = (state_q == LAUNCH);
   assign wd_en    = (state_q == RUN);

   aes128_ctrl_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (wd_load),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (launch_ok) state_d = LAUNCH;
         LAUNCH:  state_d = RUN;
         RUN:     if (done_evt || tout_evt) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         (addr_i[3:2] == 2'b10):
            rd_mux = result_q[{addr_i[1:0], 5'b0} +: 32];
         (addr_i == AES_CTRL):
            rd_mux = {26'b0, op_q, 2'b0, irq_en_q, 1'b0};
         (addr_i == AES_STATUS):
            rd_mux = {27'b0, err_to_q, err_busy_q,
                      irq_pend_q, done_q, busy};
         default: ;
      endcase
   end

   // Clears are ordered before sets so same-cycle events keep the set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         key_q       <= '0;
         data_q      <= '0;
         result_q    <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         op_q        <= '0;
         core_op_q   <= '0;
         run_first_q <= 1'b0;
         irq_en_q    <= 1'b0;
         irq_pend_q  <= 1'b0;
         done_q      <= 1'b0;
         err_busy_q  <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         rvalid_q    <= rd_i;
         run_first_q <= (state_q == LAUNCH);
         if (rd_i) rdata_q <= rd_mux;
         if (wr_key && !busy)
            key_q[{addr_i[1:0], 5'b0} +: 32] <= wdata_i;
         if (wr_data && !busy)
            data_q[{addr_i[1:0], 5'b0} +: 32] <= wdata_i;
         if (wr_ctrl) begin
            irq_en_q <= wdata_i[CTRL_IRQ_EN];
            op_q     <= wdata_i[CTRL_OP_LO +: 2];
            if (wdata_i[CTRL_IRQ_CLR]) irq_pend_q <= 1'b0;
         end
         if (wr_status) begin
            done_q     <= 1'b0;
            err_busy_q <= 1'b0;
            err_to_q   <= 1'b0;
         end
         if (launch_ok) begin
            done_q     <= 1'b0;
            err_busy_q <= 1'b0;
            err_to_q   <= 1'b0;
            core_op_q  <= wdata_i[CTRL_OP_LO +: 2];
         end
         if (reject) err_busy_q <= 1'b1;
         if (done_evt) begin
            result_q   <= core_result_i;
            done_q     <= 1'b1;
            irq_pend_q <= 1'b1;
         end
         if (tout_evt) begin
            err_to_q   <= 1'b1;
            irq_pend_q <= 1'b1;
         end
      end
   end

   assign rdata_o      = rdata_q;
   assign rvalid_o     = rvalid_q;
   assign irq_o        = irq_pend_q & irq_en_q;
   assign core_start_o = (state_q == LAUNCH);
   assign core_op_o    = core_op_q;
   assign core_key_o   = key_q;
   assign core_data_o  = data_q;

endmodule

// File: tb/tb_aes128_ctrl.sv
// Bench for aes128_ctrl: two instances (default and short watchdog), each
// driving a stub core whose result is data ^ key after a set latency.
module tb_aes128_ctrl;
   import aes128_type_pkg::*;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] R1 = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] K2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] D2 = 128'h123456789abcdef00fedcba987654321;
   localparam logic [127:0] STALE = {4{32'hdeadbeef}};

   logic        clk, rst;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic        wr, rd;
   int          sel;
   int          lat;
   logic        stale_hold;

   logic [31:0]  rdata_s;
   logic         rvalid_s, irq_s, cstart_s, cvalid_s;
   logic [1:0]   cop_s;
   logic [127:0] ckey_s;
   int           starts_s;

   int passed, checks;
   logic [127:0] model_key, model_data;
   logic [127:0] exp_q[$];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0]  rdata;
      logic         rvalid, irq, cstart, cvalid, sbusy;
      logic [1:0]   cop;
      logic [127:0] ckey, cdata, cres, pend;
      int           cnt, starts;

      aes128_ctrl #(
         .TIMEOUT_CYCLES(g == 0 ? 255 : 8)
      ) u_dut (
         .clk_i         (clk),
         .rst_i         (rst),
         .addr_i        (addr),
         .wdata_i       (wdata),
         .wr_i          (wr && (sel == g)),
         .rd_i          (rd && (sel == g)),
         .rdata_o       (rdata),
         .rvalid_o      (rvalid),
         .irq_o         (irq),
         .core_start_o  (cstart),
         .core_op_o     (cop),
         .core_key_o    (ckey),
         .core_data_o   (cdata),
         .core_result_i (cres),
         .core_valid_i  (cvalid),
         .core_ready_i  (!sbusy)
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cvalid <= 1'b0;
            sbusy  <= 1'b0;
            cnt    <= 0;
            cres   <= '0;
            pend   <= '0;
            starts <= 0;
         end else if (cstart) begin
            starts <= starts + 1;
            sbusy  <= 1'b1;
            cnt    <= lat;
            pend   <= ckey ^ cdata;
            if (stale_hold) begin
               cvalid <= 1'b1;
               cres   <= STALE;
            end else begin
               cvalid <= 1'b0;
            end
         end else if (sbusy) begin
            if (cnt <= 1) begin
               cvalid <= 1'b1;
               cres   <= pend;
               sbusy  <= 1'b0;
            end else begin
               cvalid <= 1'b0;
               cnt    <= cnt - 1;
            end
         end
      end
   end

   assign rdata_s  = (sel == 1) ? g_dut[1].rdata  : g_dut[0].rdata;
   assign rvalid_s = (sel == 1) ? g_dut[1].rvalid : g_dut[0].rvalid;
   assign irq_s    = (sel == 1) ? g_dut[1].irq    : g_dut[0].irq;
   assign cstart_s = (sel == 1) ? g_dut[1].cstart : g_dut[0].cstart;
   assign cvalid_s = (sel == 1) ? g_dut[1].cvalid : g_dut[0].cvalid;
   assign cop_s    = (sel == 1) ? g_dut[1].cop    : g_dut[0].cop;
   assign ckey_s   = (sel == 1) ? g_dut[1].ckey   : g_dut[0].ckey;
   assign starts_s = (sel == 1) ? g_dut[1].starts : g_dut[0].starts;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   // Bus tasks start and end on a falling edge.
   task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      @(negedge clk);
      wr    = 1'b0;
   endtask

   task automatic rd_reg(input logic [3:0] a, output logic [31:0] d,
                         output logic v);
      addr = a;
      rd   = 1'b1;
      @(negedge clk);
      rd   = 1'b0;
      d    = rdata_s;
      v    = rvalid_s;
   endtask

   task automatic load_block(input logic [127:0] k, input logic [127:0] d);
      for (int n = 0; n < 4; n++) wr_reg(4'(n), k[32*n +: 32]);
      for (int n = 0; n < 4; n++) wr_reg(4'(4 + n), d[32*n +: 32]);
      model_key  = k;
      model_data = d;
   endtask

   task automatic read_result(output logic [127:0] r);
      logic [31:0] w;
      logic v;
      for (int n = 0; n < 4; n++) begin
         rd_reg(4'(8 + n), w, v);
         r[32*n +: 32] = w;
      end
   endtask

   task automatic wait_idle(output bit ok);
      logic [31:0] s;
      logic v;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         rd_reg(AES_STATUS, s, v);
         if (!s[ST_BUSY]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      logic [31:0] d;
      logic v;
      checks++;
      if ({irq_s, cstart_s, cop_s} !== 4'b0) $display("FAIL reset_outs: got %b want 0000", {irq_s, cstart_s, cop_s});
      else passed++;
      checks++;
      if (ckey_s !== '0) $display("FAIL reset_key: got %h want 0", ckey_s);
      else passed++;
      rd_reg(AES_STATUS, d, v);
      checks++;
      if ({v, d} !== {1'b1, 32'h0}) $display("FAIL reset_status: got v=%b %h want v=1 0", v, d);
      else passed++;
      rd_reg(AES_CTRL, d, v);
      checks++;
      if (d !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", d);
      else passed++;
      wr_reg(AES_KEY0, 32'hcafef00d);
      rd_reg(AES_KEY0, d, v);
      checks++;
      if (d !== 32'h0) $display("FAIL key_read_zero: got %h want 0", d);
      else passed++;
      wr_reg(4'hE, 32'hffffffff);
      rd_reg(4'hE, d, v);
      checks++;
      if (d !== 32'h0) $display("FAIL unmapped_read: got %h want 0", d);
      else passed++;
   endtask

   task automatic test_normal;
      logic [31:0] s;
      logic [127:0] r, e;
      logic v;
      bit ok;
      int st0;
      lat = 20;
      load_block(K1, D1);
      wr_reg(AES_CTRL, 32'h02);
      rd_reg(AES_CTRL, s, v);
      checks++;
      if (s !== 32'h02) $display("FAIL ctrl_readback: got %h want 02", s);
      else passed++;
      st0 = starts_s;
      exp_q.push_back(model_key ^ model_data);
      wr_reg(AES_CTRL, 32'h13);
      rd_reg(AES_STATUS, s, v);
      checks++;
      if (s[ST_BUSY] !== 1'b1) $display("FAIL normal_busy: got %b want 1", s[ST_BUSY]);
      else passed++;
      checks++;
      if (cop_s !== 2'd1) $display("FAIL normal_op: got %0d want 1", cop_s);
      else passed++;
      wait_idle(ok);
      checks++;
      if (!ok) $display("FAIL normal_wait: got busy want idle");
      else passed++;
      read_result(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) $display("FAIL normal_result: got %h want %h", r, e);
      else passed++;
      checks++;
      if (r !== R1) $display("FAIL normal_vector: got %h want %h", r, R1);
      else passed++;
      rd_reg(AES_STATUS, s, v);
      checks++;
      if (s !== 32'h06) $display("FAIL normal_status: got %h want 06", s);
      else passed++;
      checks++;
      if (irq_s !== 1'b1) $display("FAIL normal_irq: got %b want 1", irq_s);
      else passed++;
      checks++;
      if (starts_s - st0 !== 1) $display("FAIL normal_starts: got %0d want 1", starts_s - st0);
      else passed++;
   endtask

   task automatic test_busy_reject;
      logic [31:0] s;
      logic [127:0] r, e;
      logic v;
      bit ok;
      int st0;
      wr_reg(AES_DATA0, 32'h11111111);
      model_data[31:0] = 32'h11111111;
      wr_reg(AES_STATUS, 32'h0);
      st0 = starts_s;
      exp_q.push_back(model_key ^ model_data);
      wr_reg(AES_CTRL, 32'h13);
      repeat (4) @(negedge clk);
      wr_reg(AES_DATA0, 32'hffffffff);
      wr_reg(AES_CTRL, 32'h13);
      rd_reg(AES_STATUS, s, v);
      checks++;
      if (s !== 32'h0D) $display("FAIL busy_status: got %h want 0d", s);
      else passed++;
      wait_idle(ok);
      checks++;
      if (!ok) $display("FAIL busy_wait: got busy want idle");
      else passed++;
      read_result(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) $display("FAIL busy_result: got %h want %h", r, e);
      else passed++;
      checks++;
      if (starts_s - st0 !== 1) $display("FAIL busy_starts: got %0d want 1", starts_s - st0);
      else passed++;
      rd_reg(AES_STATUS, s, v);
      checks++;
      if (s !== 32'h0E) $display("FAIL busy_final: got %h want 0e", s);
      else passed++;
   endtask

   task automatic test_stale_valid;
      logic [127:0] r, e;
      bit ok;
      lat = 6;
      stale_hold = 1'b1;
      exp_q.push_back(model_key ^ model_data);
      wr_reg(AES_CTRL, 32'h03);
      wait_idle(ok);
      stale_hold = 1'b0;
      read_result(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) $display("FAIL stale_result: got %h want %h", r, e);
      else passed++;
   endtask

   task automatic test_irq_race;
      logic [31:0] s;
      logic [127:0] r, e;
      logic v;
      bit found;
      wr_reg(AES_CTRL, 32'h06);
      checks++;
      if (irq_s !== 1'b0) $display("FAIL race_pre_clear: got %b want 0", irq_s);
      else passed++;
      lat = 6;
      exp_q.push_back(model_key ^ model_data);
      wr_reg(AES_CTRL, 32'h03);
      @(negedge clk);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cvalid_s) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!found) $display("FAIL race_valid: got none want core valid");
      else passed++;
      wr_reg(AES_CTRL, 32'h06);
      checks++;
      if (irq_s !== 1'b1) $display("FAIL race_set_wins: got %b want 1", irq_s);
      else passed++;
      read_result(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) $display("FAIL race_result: got %h want %h", r, e);
      else passed++;
      wr_reg(AES_CTRL, 32'h06);
      checks++;
      if (irq_s !== 1'b0) $display("FAIL race_later_clear: got %b want 0", irq_s);
      else passed++;
      rd_reg(AES_STATUS, s, v);
      checks++;
      if (s[ST_IRQ_PEND] !== 1'b0) $display("FAIL race_pend: got %b want 0", s[ST_IRQ_PEND]);
      else passed++;
   endtask

   task automatic test_timeout;
      logic [31:0] s;
      logic [127:0] r, e, prev;
      logic v;
      bit ok;
      sel = 1;
      load_block(K2, D2);
      wr_reg(AES_CTRL, 32'h02);
      lat = 3;
      exp_q.push_back(model_key ^ model_data);
      wr_reg(AES_CTRL, 32'h13);
      wait_idle(ok);
      read_result(prev);
      e = exp_q.pop_front();
      checks++;
      if (prev !== e) $display("FAIL to_first_result: got %h want %h", prev, e);
      else passed++;
      wr_reg(AES_CTRL, 32'h06);
      lat = 50;
      exp_q.push_back(e);
      wr_reg(AES_CTRL, 32'h13);
      repeat (8) @(negedge clk);
      checks++;
      if (irq_s !== 1'b0) $display("FAIL to_early: got irq %b want 0", irq_s);
      else passed++;
      @(negedge clk);
      checks++;
      if (irq_s !== 1'b1) $display("FAIL to_fire: got irq %b want 1", irq_s);
      else passed++;
      rd_reg(AES_STATUS, s, v);
      checks++;
      if (s !== 32'h14) $display("FAIL to_status: got %h want 14", s);
      else passed++;
      read_result(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) $display("FAIL to_result_kept: got %h want %h", r, e);
      else passed++;
      sel = 0;
   endtask

   task automatic test_async_reset;
      logic [31:0] s;
      logic [127:0] r, e;
      logic v;
      bit ok;
      lat = 20;
      wr_reg(AES_CTRL, 32'h13);
      repeat (3) @(negedge clk);
      rd_reg(AES_STATUS, s, v);
      checks++;
      if (s !== 32'h01) $display("FAIL rst_pre_status: got %h want 01", s);
      else passed++;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({rvalid_s, rdata_s} !== 33'h0) $display("FAIL rst_rdata: got %h want 0", {rvalid_s, rdata_s});
      else passed++;
      checks++;
      if ({cop_s, cstart_s, irq_s} !== 4'b0) $display("FAIL rst_outs: got %b want 0000", {cop_s, cstart_s, irq_s});
      else passed++;
      checks++;
      if (ckey_s !== '0) $display("FAIL rst_key: got %h want 0", ckey_s);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      load_block(K1, D1);
      exp_q.push_back(model_key ^ model_data);
      wr_reg(AES_CTRL, 32'h13);
      wait_idle(ok);
      checks++;
      if (!ok) $display("FAIL rst_rerun_wait: got busy want idle");
      else passed++;
      read_result(r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) $display("FAIL rst_rerun_result: got %h want %h", r, e);
      else passed++;
      rd_reg(AES_STATUS, s, v);
      checks++;
      if (s !== 32'h06) $display("FAIL rst_rerun_status: got %h want 06", s);
      else passed++;
   endtask

   initial begin
      passed     = 0;
      checks     = 0;
      sel        = 0;
      lat        = 20;
      stale_hold = 1'b0;
      rst        = 1'b1;
      wr         = 1'b0;
      rd         = 1'b0;
      addr       = '0;
      wdata      = '0;
      model_key  = '0;
      model_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_normal();
      test_busy_reject();
      test_stale_valid();
      test_irq_race();
      test_timeout();
      test_async_reset();
      checks++;
      if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
